usb_device_ctrl: RTL and testbench

- Parametrised device-level USB controller that sits beside the SIE in the USB top.
- Owns pull-up attach sequencing, bus-reset and suspend/resume detection from SIE line state, and the chapter-9 device state (address, configuration).
- Supplies device address and state to the protocol layers and pull-up/status outputs to the top.

---
 rtl/usb_pkg.sv | 28 ++
 rtl/usb_line_timer.sv | 37 +++
 rtl/usb_device_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_usb_device_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_pkg.sv
// Shared types, default timing constants and counter-sizing helper for the
// USB device controller slice.
package usb_pkg;

   typedef enum logic [2:0] {
      DETACHED   = 3'd0,
      ATTACHED   = 3'd1,
      DEFAULT    = 3'd2,
      ADDRESS    = 3'd3,
      CONFIGURED = 3'd4
   } usb_dev_state_t;

   typedef enum logic [1:0] {
      LS_SE0 = 2'd0,
      LS_J   = 2'd1,
      LS_K   = 2'd2,
      LS_SE1 = 2'd3
   } usb_line_state_t;

   localparam int unsigned ATTACH_DELAY_DEF = 32'd4800;
   localparam int unsigned RESET_SE0_DEF    = 32'd120;
   localparam int unsigned SUSPEND_IDLE_DEF = 32'd144000;

   function automatic int unsigned cnt_width(input int unsigned match);
      return $clog2(match + 32'd1);
   endfunction

endpackage

// File: rtl/usb_line_timer.sv
// Saturating match counter: counts enabled cycles, clears on clr, and raises a
// combinational hit on the cycle that completes MATCH consecutive counts.
module usb_line_timer
   import usb_pkg::*;
#(
   parameter int unsigned MATCH = 32'd4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic clr,
   output logic hit
);

   localparam int unsigned CW = cnt_width(MATCH);
   localparam logic [CW-1:0] LAST = CW'(MATCH - 32'd1);
   localparam logic [CW-1:0] FULL = CW'(MATCH);

   logic [CW-1:0] count_r;

   // Holding at FULL keeps a long qualifying condition from firing twice.
   assign hit = en && !clr && (count_r == LAST);

   // Run-length counter with saturation.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_r <= '0;
      end else if (clr) begin
         count_r <= '0;
      end else if (en && (count_r != FULL)) begin
         count_r <= count_r + CW'(1);
      end else begin
         count_r <= count_r;
      end
   end

endmodule

// File: rtl/usb_device_ctrl.sv
// Device-level USB control: pull-up attach, bus reset / suspend / resume, and
// chapter-9 address/config state. Debug LEDs exist only with USB_DEBUG_LEDS_EN.
module usb_device_ctrl
   import usb_pkg::*;
#(
   parameter int unsigned ATTACH_DELAY_CYCLES = ATTACH_DELAY_DEF,
   parameter int unsigned RESET_SE0_CYCLES    = RESET_SE0_DEF,
   parameter int unsigned SUSPEND_IDLE_CYCLES = SUSPEND_IDLE_DEF,
   parameter int unsigned ADDR_W              = 32'd7
) (
   input  logic              clk48,
   input  logic              rst_n,
   input  logic [1:0]        line_state,
   input  logic              attach_req,
   input  logic              addr_pending_valid,
   input  logic [ADDR_W-1:0] addr_pending,
   input  logic              status_done,
   input  logic              cfg_valid,
   input  logic [7:0]        cfg_value,
   output logic              USB_PULLUP,
   output usb_dev_state_t    dev_state,
   output logic [ADDR_W-1:0] dev_addr,
   output logic [7:0]        cfg_active,
   output logic              bus_reset,
   output logic              suspended,
`ifdef USB_DEBUG_LEDS_EN
   output logic              LED_R,
   output logic              LED_G,
   output logic              LED_B,
`endif
   output logic              resume_pulse
);

   usb_dev_state_t    state_r, state_nxt_s;
   logic              pullup_r, pullup_nxt_s;
   logic [ADDR_W-1:0] dev_addr_r, dev_addr_nxt_s, pend_addr_r, pend_addr_nxt_s;
   logic              pend_flag_r, pend_flag_nxt_s;
   logic [7:0]        cfg_r, cfg_nxt_s;
   logic              bus_reset_r, bus_reset_nxt_s;
   logic              suspended_r, suspended_nxt_s;
   logic              resume_r, resume_nxt_s;
   logic              attach_en_s, se0_en_s, idle_en_s, idle_clr_s;
   logic              attach_hit_s, se0_hit_s, idle_hit_s;
   logic              commit_s, cfg_ok_s;

   assign attach_en_s = attach_req && (state_r == DETACHED);
   assign se0_en_s    = (line_state == LS_SE0) && (state_r != DETACHED);
   assign idle_en_s   = (line_state == LS_J) && !suspended_r;
   assign idle_clr_s  = (line_state != LS_J);
   assign commit_s    = status_done && pend_flag_r && (state_r != DETACHED);
   assign cfg_ok_s    = cfg_valid && ((state_r == ADDRESS) || (state_r == CONFIGURED));

   usb_line_timer #(.MATCH(ATTACH_DELAY_CYCLES)) u_attach_timer (
      .clk(clk48), .rst_n(rst_n), .en(attach_en_s), .clr(!attach_en_s), .hit(attach_hit_s)
   );

   usb_line_timer #(.MATCH(RESET_SE0_CYCLES)) u_se0_timer (
      .clk(clk48), .rst_n(rst_n), .en(se0_en_s), .clr(!se0_en_s), .hit(se0_hit_s)
   );

   usb_line_timer #(.MATCH(SUSPEND_IDLE_CYCLES)) u_idle_timer (
      .clk(clk48), .rst_n(rst_n), .en(idle_en_s), .clr(idle_clr_s), .hit(idle_hit_s)
   );

   // Device state, address and configuration: detach > bus reset > commit.
   always_comb begin
      state_nxt_s     = state_r;
      pullup_nxt_s    = pullup_r;
      dev_addr_nxt_s  = dev_addr_r;
      cfg_nxt_s       = cfg_r;
      bus_reset_nxt_s = 1'b0;
      if (!attach_req) begin
         state_nxt_s    = DETACHED;
         pullup_nxt_s   = 1'b0;
         dev_addr_nxt_s = '0;
         cfg_nxt_s      = 8'd0;
      end else if (se0_hit_s) begin
         state_nxt_s     = DEFAULT;
         dev_addr_nxt_s  = '0;
         cfg_nxt_s       = 8'd0;
         bus_reset_nxt_s = 1'b1;
      end else if (state_r == DETACHED) begin
         if (attach_hit_s) begin
            state_nxt_s  = ATTACHED;
            pullup_nxt_s = 1'b1;
         end else begin
            state_nxt_s = state_r;
         end
      end else if (commit_s) begin
         dev_addr_nxt_s = pend_addr_r;
         if ((state_r == DEFAULT) && (pend_addr_r != '0)) begin
            state_nxt_s = ADDRESS;
         end else if ((state_r == ADDRESS) && (pend_addr_r == '0)) begin
            state_nxt_s = DEFAULT;
         end else begin
            state_nxt_s = state_r;
         end
      end else if (cfg_ok_s) begin
         cfg_nxt_s = cfg_value;
         if (cfg_value != 8'd0) begin
            state_nxt_s = CONFIGURED;
         end else begin
            state_nxt_s = ADDRESS;
         end
      end else begin
         state_nxt_s = state_r;
      end
   end

   // Pending SET_ADDRESS and suspend/resume tracking.
   always_comb begin
      pend_addr_nxt_s = pend_addr_r;
      pend_flag_nxt_s = pend_flag_r;
      suspended_nxt_s = suspended_r;
      resume_nxt_s    = 1'b0;
      if (!attach_req || se0_hit_s) begin
         pend_addr_nxt_s = '0;
         pend_flag_nxt_s = 1'b0;
      end else if (addr_pending_valid) begin
         pend_addr_nxt_s = addr_pending;
         pend_flag_nxt_s = 1'b1;
      end else if (commit_s) begin
         pend_flag_nxt_s = 1'b0;
      end else begin
         pend_flag_nxt_s = pend_flag_r;
      end
      if (!attach_req || se0_hit_s) begin
         suspended_nxt_s = 1'b0;
      end else if (!suspended_r && idle_hit_s) begin
         suspended_nxt_s = 1'b1;
      end else if (suspended_r && (line_state == LS_K)) begin
         suspended_nxt_s = 1'b0;
         resume_nxt_s    = 1'b1;
      end else begin
         suspended_nxt_s = suspended_r;
      end
   end

   // Output and state registers.
   always_ff @(posedge clk48) begin
      if (!rst_n) begin
         state_r     <= DETACHED;
         pullup_r    <= 1'b0;
         dev_addr_r  <= '0;
         pend_addr_r <= '0;
         pend_flag_r <= 1'b0;
         cfg_r       <= 8'd0;
         bus_reset_r <= 1'b0;
         suspended_r <= 1'b0;
         resume_r    <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         pullup_r    <= pullup_nxt_s;
         dev_addr_r  <= dev_addr_nxt_s;
         pend_addr_r <= pend_addr_nxt_s;
         pend_flag_r <= pend_flag_nxt_s;
         cfg_r       <= cfg_nxt_s;
         bus_reset_r <= bus_reset_nxt_s;
         suspended_r <= suspended_nxt_s;
         resume_r    <= resume_nxt_s;
      end
   end

   assign USB_PULLUP   = pullup_r;
   assign dev_state    = state_r;
   assign dev_addr     = dev_addr_r;
   assign cfg_active   = cfg_r;
   assign bus_reset    = bus_reset_r;
   assign suspended    = suspended_r;
   assign resume_pulse = resume_r;

`ifdef USB_DEBUG_LEDS_EN
   logic led_r_r, led_g_r, led_b_r;

   // LEDs follow the next-state values so they line up with the status outputs.
   always_ff @(posedge clk48) begin
      if (!rst_n) begin
         led_r_r <= 1'b0;
         led_g_r <= 1'b0;
         led_b_r <= 1'b0;
      end else begin
         led_r_r <= suspended_nxt_s;
         led_g_r <= (state_nxt_s == CONFIGURED);
         led_b_r <= led_b_r ^ bus_reset_nxt_s;
      end
   end

   assign LED_R = led_r_r;
   assign LED_G = led_g_r;
   assign LED_B = led_b_r;
`endif

endmodule

// File: tb/tb_usb_device_ctrl.sv
// Self-checking bench for usb_device_ctrl: directed test-plan steps followed by
// randomized traffic, all compared against a run-length behavioural model.
module tb_usb_device_ctrl;
   import usb_pkg::*;

   localparam int ATT = 8;
   localparam int RST = 4;
   localparam int SUS = 20;
   localparam int AW  = 7;

   logic          clk48 = 1'b0;
   logic          rst_n, attach_req, addr_pending_valid, status_done, cfg_valid;
   logic [1:0]    line_state;
   logic [AW-1:0] addr_pending;
   logic [7:0]    cfg_value;
   logic          USB_PULLUP, bus_reset, suspended, resume_pulse;
   usb_dev_state_t dev_state;
   logic [AW-1:0] dev_addr;
   logic [7:0]    cfg_active;
`ifdef USB_DEBUG_LEDS_EN
   logic          LED_R, LED_G, LED_B;
`endif

   int n_pass = 0;
   int n_total = 0;
   int n_fail = 0;

   // reference model state: ints for state (0 detached .. 4 configured)
   int m_state, m_addr, m_cfg, m_pend_addr;
   bit m_pullup, m_pend, m_susp, e_bus_reset, e_resume;
   int att_run, se0_run, idle_run;

   always #5 clk48 = ~clk48;

   usb_device_ctrl #(
      .ATTACH_DELAY_CYCLES(ATT), .RESET_SE0_CYCLES(RST),
      .SUSPEND_IDLE_CYCLES(SUS), .ADDR_W(AW)
   ) dut (
      .clk48(clk48), .rst_n(rst_n), .line_state(line_state), .attach_req(attach_req),
      .addr_pending_valid(addr_pending_valid), .addr_pending(addr_pending),
      .status_done(status_done), .cfg_valid(cfg_valid), .cfg_value(cfg_value),
      .USB_PULLUP(USB_PULLUP), .dev_state(dev_state), .dev_addr(dev_addr),
      .cfg_active(cfg_active), .bus_reset(bus_reset), .suspended(suspended),
`ifdef USB_DEBUG_LEDS_EN
      .LED_R(LED_R), .LED_G(LED_G), .LED_B(LED_B),
`endif
      .resume_pulse(resume_pulse)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Predicts the outputs after the coming edge from the current inputs.
   task automatic model_step();
      bit att_fire, se0_fire, idle_fire, commit, cfg_ok;
      e_bus_reset = 1'b0;
      e_resume    = 1'b0;
      if (!rst_n) begin
         m_state = 0; m_pullup = 1'b0; m_addr = 0; m_cfg = 0; m_pend = 1'b0;
         m_pend_addr = 0; m_susp = 1'b0; att_run = 0; se0_run = 0; idle_run = 0;
         return;
      end
      att_run = (attach_req && m_state == 0) ? att_run + 1 : 0;
      se0_run = (line_state == 2'd0 && m_state != 0) ? se0_run + 1 : 0;
      if (line_state != 2'd1) idle_run = 0;
      else if (!m_susp) idle_run++;
      att_fire  = (att_run == ATT);
      se0_fire  = (se0_run == RST);
      idle_fire = (line_state == 2'd1) && !m_susp && (idle_run == SUS);
      commit    = status_done && m_pend && (m_state != 0);
      cfg_ok    = cfg_valid && (m_state >= 3);

      if (!attach_req || se0_fire) m_susp = 1'b0;
      else if (!m_susp && idle_fire) m_susp = 1'b1;
      else if (m_susp && line_state == 2'd2) begin
         m_susp = 1'b0;
         e_resume = 1'b1;
      end

      if (!attach_req) begin
         m_state = 0; m_pullup = 1'b0; m_addr = 0; m_cfg = 0;
      end else if (se0_fire) begin
         m_state = 2; m_addr = 0; m_cfg = 0; e_bus_reset = 1'b1;
      end else if (m_state == 0) begin
         if (att_fire) begin
            m_state = 1; m_pullup = 1'b1;
         end
      end else if (commit) begin
         if (m_state == 2 && m_pend_addr != 0) m_state = 3;
         else if (m_state == 3 && m_pend_addr == 0) m_state = 2;
         m_addr = m_pend_addr;
      end else if (cfg_ok) begin
         m_cfg   = int'(cfg_value);
         m_state = (cfg_value != 8'd0) ? 4 : 3;
      end

      if (!attach_req || se0_fire) begin
         m_pend = 1'b0; m_pend_addr = 0;
      end else if (addr_pending_valid) begin
         m_pend = 1'b1; m_pend_addr = int'(addr_pending);
      end else if (commit) begin
         m_pend = 1'b0;
      end
   endtask

   task automatic step();
      model_step();
      @(posedge clk48);
      #1;
      chk("pullup",    32'(USB_PULLUP),   32'(m_pullup));
      chk("dev_state", 32'(dev_state),    32'(m_state));
      chk("dev_addr",  32'(dev_addr),     32'(m_addr));
      chk("cfg",       32'(cfg_active),   32'(m_cfg));
      chk("bus_reset", 32'(bus_reset),    32'(e_bus_reset));
      chk("suspended", 32'(suspended),    32'(m_susp));
      chk("resume",    32'(resume_pulse), 32'(e_resume));
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      int pulses;
      int run_left;
      rst_n = 1'b0; attach_req = 1'b0; line_state = 2'd2;
      addr_pending_valid = 1'b0; addr_pending = '0; status_done = 1'b0;
      cfg_valid = 1'b0; cfg_value = 8'd0;
      steps(2);
      chk("rst_state", 32'(dev_state), 32'(DETACHED));
      chk("rst_pullup", 32'(USB_PULLUP), 32'd0);

      // attach: short request then full delay
      rst_n = 1'b1; attach_req = 1'b1;
      steps(5);
      attach_req = 1'b0;
      step();
      chk("short_attach_pullup", 32'(USB_PULLUP), 32'd0);
      attach_req = 1'b1;
      steps(7);
      chk("attach_7_pullup", 32'(USB_PULLUP), 32'd0);
      step();
      chk("attach_pullup", 32'(USB_PULLUP), 32'd1);
      chk("attach_state", 32'(dev_state), 32'(ATTACHED));

      // bus reset qualification
      pulses = 0;
      line_state = 2'd0;
      for (int i = 0; i < 3; i++) begin step(); pulses += int'(bus_reset); end
      line_state = 2'd1;
      step(); pulses += int'(bus_reset);
      chk("short_se0_pulses", 32'(pulses), 32'd0);
      line_state = 2'd0;
      for (int i = 0; i < 50; i++) begin step(); pulses += int'(bus_reset); end
      chk("long_se0_pulses", 32'(pulses), 32'd1);
      chk("reset_state", 32'(dev_state), 32'(DEFAULT));
      chk("reset_addr", 32'(dev_addr), 32'd0);

      // SET_ADDRESS
      line_state = 2'd2;
      addr_pending_valid = 1'b1; addr_pending = 7'h2A;
      step();
      addr_pending_valid = 1'b0;
      steps(2);
      chk("addr_before_status", 32'(dev_addr), 32'd0);
      status_done = 1'b1;
      step();
      chk("addr_commit", 32'(dev_addr), 32'h2A);
      chk("addr_state", 32'(dev_state), 32'(ADDRESS));
      step();
      status_done = 1'b0;
      chk("status_alone_addr", 32'(dev_addr), 32'h2A);
      chk("status_alone_state", 32'(dev_state), 32'(ADDRESS));

      // configuration
      cfg_valid = 1'b1; cfg_value = 8'd1;
      step();
      chk("cfg1_state", 32'(dev_state), 32'(CONFIGURED));
      chk("cfg1_val", 32'(cfg_active), 32'd1);
      cfg_value = 8'd0;
      step();
      cfg_valid = 1'b0;
      chk("cfg0_state", 32'(dev_state), 32'(ADDRESS));
      line_state = 2'd0;
      steps(4);
      line_state = 2'd2;
      cfg_valid = 1'b1; cfg_value = 8'd1;
      step();
      cfg_valid = 1'b0;
      chk("cfg_default_state", 32'(dev_state), 32'(DEFAULT));
      chk("cfg_default_val", 32'(cfg_active), 32'd0);

      // back to CONFIGURED, then suspend/resume
      addr_pending_valid = 1'b1; addr_pending = 7'h2A;
      step();
      addr_pending_valid = 1'b0; status_done = 1'b1;
      step();
      status_done = 1'b0; cfg_valid = 1'b1; cfg_value = 8'd1;
      step();
      cfg_valid = 1'b0;
      line_state = 2'd1;
      steps(19);
      chk("idle19_susp", 32'(suspended), 32'd0);
      step();
      chk("idle20_susp", 32'(suspended), 32'd1);
      chk("susp_state", 32'(dev_state), 32'(CONFIGURED));
      steps(5);
      line_state = 2'd2;
      step();
      chk("resume_pulse", 32'(resume_pulse), 32'd1);
      chk("resume_susp", 32'(suspended), 32'd0);
      step();
      chk("resume_once", 32'(resume_pulse), 32'd0);
      line_state = 2'd1;
      steps(20);
      chk("resusp", 32'(suspended), 32'd1);
      line_state = 2'd0;
      steps(4);
      chk("susp_reset_state", 32'(dev_state), 32'(DEFAULT));
      chk("susp_reset_susp", 32'(suspended), 32'd0);

      // detach beats a coincident bus reset
      line_state = 2'd2;
      step();
      line_state = 2'd0;
      steps(3);
      attach_req = 1'b0;
      step();
      chk("prio_state", 32'(dev_state), 32'(DETACHED));
      chk("prio_bus_reset", 32'(bus_reset), 32'd0);

      // reset in the middle of an attach count
      line_state = 2'd2; attach_req = 1'b1;
      steps(4);
      rst_n = 1'b0;
      step();
      chk("midrst_pullup", 32'(USB_PULLUP), 32'd0);
      chk("midrst_state", 32'(dev_state), 32'(DETACHED));
      rst_n = 1'b1;
      steps(7);
      chk("postrst_7", 32'(USB_PULLUP), 32'd0);
      step();
      chk("postrst_8", 32'(USB_PULLUP), 32'd1);

      // randomized traffic
      run_left = 0;
      for (int n = 0; n < 3000; n++) begin
         if (run_left == 0) begin
            line_state = 2'($urandom_range(0, 3));
            run_left = ($urandom_range(0, 3) == 0) ? int'($urandom_range(15, 30))
                                                   : int'($urandom_range(1, 6));
         end
         run_left--;
         if (attach_req) attach_req = ($urandom_range(0, 299) != 0);
         else attach_req = ($urandom_range(0, 3) == 0);
         rst_n = ($urandom_range(0, 999) != 0);
         addr_pending_valid = ($urandom_range(0, 11) == 0);
         addr_pending = ($urandom_range(0, 3) == 0) ? 7'd0 : 7'($urandom_range(1, 127));
         status_done = ($urandom_range(0, 7) == 0);
         cfg_valid = ($urandom_range(0, 7) == 0);
         cfg_value = 8'($urandom_range(0, 3));
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
